adder_rr_arbiter: RTL and testbench

Round-robin arbiter and two-stage pipeline that shares one `maxn`-bit ripple adder among `NREQ` requesters. Each requester presents an operand pair under a valid/ready handshake. The arbiter grants at most one request per cycle, registers the operands, then registers the sum and carry-out. The result is returned with the winning requester's index under a valid/ready output handshake with full backpressure.

---
 rtl/adder_arb_pkg.sv | 23 ++
 rtl/adder1.sv | 13 +
 rtl/adder_rr_pick.sv | 36 +++
 rtl/adder_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_adder_rr_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared constants, index-width helper and the operand-stage record for the
// round-robin shared-adder arbiter.
package adder_arb_pkg;

    localparam int MAXN_DEF = 16;
    localparam int NREQ_DEF = 4;

    // Index width with a floor of one bit so a single-requester build still has a port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDW_DEF = id_width(NREQ_DEF);

    // Operand-stage record; field widths track the default build of the arbiter.
    typedef struct packed {
        logic                valid;
        logic [IDW_DEF-1:0]  id;
        logic [MAXN_DEF-1:0] x;
        logic [MAXN_DEF-1:0] y;
    } stage_a_t;

endpackage

// File: rtl/adder1.sv
// Single-bit full-adder cell; chained to build the ripple adder.
module adder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// scanning upward and wrapping to index 0.
module adder_rr_pick
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  sel
);

    logic [IDW-1:0]  cand [NREQ];
    logic [NREQ-1:0] hit;

    // cand[k] is the requester examined k places after the pointer.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        assign cand[gi] = IDW'((int'(ptr) + gi) % NREQ);
        assign hit[gi]  = req_valid[cand[gi]];
    end

    assign any = |req_valid;

    // Walk from the far end so the nearest hit to ptr wins.
    always_comb begin
        sel = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                sel = cand[k];
            end
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter feeding a shared ripple adder through an operand register
// and a result register, with full backpressure on the result handshake.
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int maxn = MAXN_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*maxn-1:0] req_x,
    input  logic [NREQ*maxn-1:0] req_y,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [maxn-1:0]      resp_sum,
    output logic                 resp_cout
);

    stage_a_t        a_reg, a_next;
    logic [IDW-1:0]  ptr_reg, ptr_next;
    logic            resp_valid_reg, resp_valid_next;
    logic [IDW-1:0]  resp_id_reg, resp_id_next;
    logic [maxn-1:0] resp_sum_reg, resp_sum_next;
    logic            resp_cout_reg, resp_cout_next;

    logic            any;
    logic [IDW-1:0]  sel;
    logic            b_free, a_free, accept;
    logic [maxn-1:0] x_sel, y_sel, sum;
    logic [maxn:0]   carry;

    adder_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr_reg),
        .any       (any),
        .sel       (sel)
    );

    assign b_free = !resp_valid_reg || resp_ready;
    assign a_free = !a_reg.valid || b_free;
    assign accept = a_free && any && !rst;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = accept && (sel == IDW'(gi));
    end

    assign x_sel = req_x[sel*maxn +: maxn];
    assign y_sel = req_y[sel*maxn +: maxn];

    // The only arithmetic path: registered operands in, registered result out.
    assign carry[0] = 1'b0;
    for (genvar gi = 0; gi < maxn; gi++) begin : g_add
        adder1 u_cell (
            .a    (a_reg.x[gi]),
            .b    (a_reg.y[gi]),
            .cin  (carry[gi]),
            .s    (sum[gi]),
            .cout (carry[gi+1])
        );
    end

    always_comb begin
        a_next          = a_reg;
        ptr_next        = ptr_reg;
        resp_valid_next = resp_valid_reg;
        resp_id_next    = resp_id_reg;
        resp_sum_next   = resp_sum_reg;
        resp_cout_next  = resp_cout_reg;

        if (accept) begin
            a_next.valid = 1'b1;
            a_next.id    = sel;
            a_next.x     = x_sel;
            a_next.y     = y_sel;
            ptr_next     = (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;
        end else if (b_free) begin
            a_next.valid = 1'b0;
        end

        if (b_free) begin
            if (a_reg.valid) begin
                resp_valid_next = 1'b1;
                resp_id_next    = a_reg.id;
                resp_sum_next   = sum;
                resp_cout_next  = carry[maxn];
            end else begin
                resp_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg          <= '0;
            ptr_reg        <= '0;
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= '0;
            resp_sum_reg   <= '0;
            resp_cout_reg  <= 1'b0;
        end else begin
            a_reg          <= a_next;
            ptr_reg        <= ptr_next;
            resp_valid_reg <= resp_valid_next;
            resp_id_reg    <= resp_id_next;
            resp_sum_reg   <= resp_sum_next;
            resp_cout_reg  <= resp_cout_next;
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_id    = resp_id_reg;
    assign resp_sum   = resp_sum_reg;
    assign resp_cout  = resp_cout_reg;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Scoreboard bench: grants push hand-computed results, a monitor pops and
// compares each consumed response, grant order and stall stability.
module tb_adder_rr_arbiter;

    localparam int MAXN = 16;
    localparam int NR   = 4;
    localparam int IW   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR-1:0]      req_valid = '0;
    logic [NR-1:0]      req_ready;
    logic [NR*MAXN-1:0] req_x = '0;
    logic [NR*MAXN-1:0] req_y = '0;
    logic               resp_valid;
    logic               resp_ready = 1'b1;
    logic [IW-1:0]      resp_id;
    logic [MAXN-1:0]    resp_sum;
    logic               resp_cout;

    always #5 clk = ~clk;

    adder_rr_arbiter #(
        .maxn (MAXN),
        .NREQ (NR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout)
    );

    // Directed vectors with hand-computed sums and carries.
    logic [15:0] vx [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF, 16'hAAAA, 16'hFFFF, 16'h0F0F};
    logic [15:0] vy [8] = '{16'h0FCD, 16'h0001, 16'h8000, 16'h0002, 16'h0001, 16'h5555, 16'hFFFF, 16'hF0F1};
    logic [15:0] vs [8] = '{16'h2201, 16'h0000, 16'h0000, 16'h0003, 16'h8000, 16'hFFFF, 16'hFFFE, 16'h0000};
    logic        vc [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    typedef struct {
        int          id;
        logic [15:0] sum;
        logic        cout;
        int          acc;
        bit          strict;
    } exp_t;

    exp_t sb[$];
    int   exp_grant[$];

    int pend_v [NR][32];
    int pend_n [NR] = '{default: 0};
    int pend_h [NR] = '{default: 0};
    bit acc_flag [NR] = '{default: 1'b0};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nacc = 0;
    bit force_all = 1'b1;
    bit strict = 1'b0;
    bit stall_prev = 1'b0;
    logic [IW+MAXN+1:0] snap = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic add(input int r, input int v);
        pend_v[r][pend_n[r]] = v;
        pend_n[r] = pend_n[r] + 1;
    endtask

    function automatic bit pend_done();
        for (int i = 0; i < NR; i++) begin
            if (pend_h[i] < pend_n[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_drain(input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (sb.size() == 0) && !resp_valid && pend_done();
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    // Requester model: present the head vector until it is accepted.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc_flag[i]) pend_h[i] = pend_h[i] + 1;
            if (force_all) begin
                req_valid[i] = 1'b1;
                req_x[i*MAXN +: MAXN] = '0;
                req_y[i*MAXN +: MAXN] = '0;
            end else if (pend_h[i] < pend_n[i]) begin
                req_valid[i] = 1'b1;
                req_x[i*MAXN +: MAXN] = vx[pend_v[i][pend_h[i]]];
                req_y[i*MAXN +: MAXN] = vy[pend_v[i][pend_h[i]]];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    // Monitor: grants push expectations, consumed responses pop and compare.
    always @(negedge clk) begin
        int   gcount;
        int   g;
        int   v;
        exp_t e;
        gcount = 0;
        if (rst) chk("ready_in_reset", 32'(req_ready), 32'd0);
        for (int i = 0; i < NR; i++) begin
            acc_flag[i] = req_valid[i] && req_ready[i];
            if (acc_flag[i]) begin
                gcount++;
                nacc++;
                if (exp_grant.size() > 0) begin
                    g = exp_grant.pop_front();
                    chk("grant_order", 32'(i), 32'(g));
                end
                v = pend_v[i][pend_h[i]];
                e.id = i;
                e.sum = vs[v];
                e.cout = vc[v];
                e.acc = cyc;
                e.strict = strict;
                sb.push_back(e);
            end
        end
        if (gcount > 1) chk("onehot_grant", 32'(gcount), 32'd1);
        if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 32'(resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_id", 32'(resp_id), 32'(e.id));
                chk("resp_sum", 32'(resp_sum), 32'(e.sum));
                chk("resp_cout", 32'(resp_cout), 32'(e.cout));
                if (e.strict) chk("latency", 32'(cyc - e.acc), 32'd2);
            end
        end
        if (stall_prev) chk("stall_stable", 32'({resp_valid, resp_id, resp_sum, resp_cout}), 32'(snap));
        stall_prev = resp_valid && !resp_ready && !rst;
        snap = {resp_valid, resp_id, resp_sum, resp_cout};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Reset with every requester asserting valid.
        repeat (3) @(negedge clk);
        @(posedge clk); #2 force_all = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_sum", 32'(resp_sum), 32'd0);
        chk("rst_resp_cout", 32'(resp_cout), 32'd0);

        // Single request from requester 2.
        @(posedge clk); #2;
        strict = 1'b1;
        exp_grant.push_back(2);
        add(2, 0);
        wait_drain(20);

        // Wrap and carry, back to back on requester 3.
        @(posedge clk); #2;
        exp_grant.push_back(3);
        exp_grant.push_back(3);
        add(3, 1);
        add(3, 2);
        wait_drain(20);

        // All four contending: 0,1,2,3 repeating, one per cycle.
        @(posedge clk); #2;
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < NR; r++) begin
                exp_grant.push_back(r);
                add(r, (r * 3 + k) % 8);
            end
        end
        wait_drain(40);

        // Solo grant to 3, then 0 and 3 contend.
        @(posedge clk); #2;
        exp_grant.push_back(3);
        add(3, 3);
        wait_drain(20);
        @(posedge clk); #2;
        exp_grant.push_back(0);
        exp_grant.push_back(3);
        add(0, 4);
        add(3, 5);
        wait_drain(20);

        // Backpressure: two accepts fill A and B, then everything stalls.
        @(posedge clk); #2;
        resp_ready = 1'b0;
        strict = 1'b0;
        base = nacc;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < NR; r++) begin
                exp_grant.push_back(r);
                add(r, (r + k * 4) % 8);
            end
        end
        repeat (6) @(negedge clk);
        chk("stall_accepts", 32'(nacc - base), 32'd2);
        chk("stall_ready", 32'(req_ready), 32'd0);
        chk("stall_resp_valid", 32'(resp_valid), 32'd1);
        @(posedge clk); #2 resp_ready = 1'b1;
        wait_drain(60);

        // Reset while both stages hold data; pointer must return to 0.
        @(posedge clk); #2;
        resp_ready = 1'b0;
        base = nacc;
        exp_grant.push_back(1);
        exp_grant.push_back(2);
        add(1, 4);
        add(1, 5);
        add(2, 6);
        add(3, 7);
        repeat (6) @(negedge clk);
        chk("pre_rst_accepts", 32'(nacc - base), 32'd2);
        chk("pre_rst_resp_valid", 32'(resp_valid), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        sb.delete();
        exp_grant.delete();
        @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        resp_ready = 1'b1;
        strict = 1'b1;
        exp_grant.push_back(1);
        exp_grant.push_back(3);
        @(negedge clk);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_resp_sum", 32'(resp_sum), 32'd0);
        chk("midrst_resp_id", 32'(resp_id), 32'd0);
        wait_drain(30);

        chk("grants_left", 32'(exp_grant.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
